// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// Purpose : bundles the two master request channels and the nvm_mem side of
//           the shared-memory arbiter into one interface.
// Signals : m0_* / m1_*  req, we, addr, wdata (master -> arbiter),
//                        gnt, rdata, rvalid (arbiter -> master)
//           mem_*        wr_en, addr, data_in (arbiter -> nvm_mem),
//                        data_out (nvm_mem -> arbiter)
//           arb_owner    master owning the bus while any gnt is high
// Modports: slave  - the arbiter side
//           master - the environment side (masters plus memory)
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_rvalid;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_rvalid;

    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  arb_owner;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_data_out,
        output m0_gnt, m0_rdata, m0_rvalid,
        output m1_gnt, m1_rdata, m1_rvalid,
        output mem_wr_en, mem_addr, mem_data_in, arb_owner
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_data_out,
        input  m0_gnt, m0_rdata, m0_rvalid,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  mem_wr_en, mem_addr, mem_data_in, arb_owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Purpose : shares the single-port nvm_mem between master M0 (cpu) and
//           master M1 (boot loader / DMA). Single-beat req/gnt handshake,
//           round-robin arbitration with bursts bounded to MAX_BURST beats
//           while the other master is waiting.
// Ports   : sys_clk  - system clock, rising edge
//           sys_rst  - synchronous active-high reset; also gates gnt and
//                      mem_wr_en low in the cycle it is asserted
//           bus      - mem_bus_arbiter_if.slave (master channels + nvm_mem)
//           stat_gnt0/stat_gnt1/stat_conflict - 32-bit event counters,
//                      present only when MEM_ARB_STATS_EN is defined
// Options : `define MEM_ARB_STATS_EN to add the statistics counters.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    mem_bus_arbiter_if.slave   bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]        stat_gnt0,
    output logic [31:0]        stat_gnt1,
    output logic [31:0]        stat_conflict
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    // One extra bit of headroom keeps the width legal for MAX_BURST == 1.
    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST - 1);

    state_e                  state_q, state_d;
    logic                    last_q, last_d;
    logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic [DATA_WIDTH-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0]   m1_rdata_q, m1_rdata_d;
    logic                    m0_rvalid_q, m0_rvalid_d;
    logic                    m1_rvalid_q, m1_rvalid_d;

    logic                    m0_gnt_s;
    logic                    m1_gnt_s;
    logic                    mem_wr_en_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_s;
    logic [DATA_WIDTH-1:0]   mem_data_in_s;
    logic                    arb_owner_s;

    // Next-state selection: round robin on a tie from IDLE, bounded burst under contention.
    always_comb begin
        state_d = IDLE;
        if (bus.m0_req && bus.m1_req) begin
            case (state_q)
                GNT0:    state_d = (burst_cnt_q < BURST_LIM) ? GNT0 : GNT1;
                GNT1:    state_d = (burst_cnt_q < BURST_LIM) ? GNT1 : GNT0;
                default: state_d = last_q ? GNT0 : GNT1;
            endcase
        end else if (bus.m0_req) begin
            state_d = GNT0;
        end else if (bus.m1_req) begin
            state_d = GNT1;
        end else begin
            state_d = IDLE;
        end
    end

    // Burst counter and last-owner tracking; the counter saturates when the owner runs unopposed.
    always_comb begin
        burst_cnt_d = '0;
        if ((state_d != IDLE) && (state_d == state_q)) begin
            if (burst_cnt_q < BURST_LIM) begin
                burst_cnt_d = burst_cnt_q + CNT_W'(1'b1);
            end else begin
                burst_cnt_d = burst_cnt_q;
            end
        end else begin
            burst_cnt_d = '0;
        end

        case (state_q)
            GNT0:    last_d = 1'b0;
            GNT1:    last_d = 1'b1;
            default: last_d = last_q;
        endcase
    end

    // Grant and memory-side decode; sys_rst blocks any grant or write in the cycle it is seen.
    always_comb begin
        m0_gnt_s      = 1'b0;
        m1_gnt_s      = 1'b0;
        mem_wr_en_s   = 1'b0;
        mem_addr_s    = '0;
        mem_data_in_s = '0;
        arb_owner_s   = 1'b0;
        case (state_q)
            GNT0: begin
                m0_gnt_s      = ~sys_rst;
                mem_wr_en_s   = bus.m0_we & ~sys_rst;
                mem_addr_s    = bus.m0_addr;
                mem_data_in_s = bus.m0_wdata;
                arb_owner_s   = 1'b0;
            end
            GNT1: begin
                m1_gnt_s      = ~sys_rst;
                mem_wr_en_s   = bus.m1_we & ~sys_rst;
                mem_addr_s    = bus.m1_addr;
                mem_data_in_s = bus.m1_wdata;
                arb_owner_s   = 1'b1;
            end
            default: begin
                m0_gnt_s = 1'b0;
                m1_gnt_s = 1'b0;
            end
        endcase
    end

    // Read return path: capture memory data at the end of a read grant, pulse rvalid next cycle.
    always_comb begin
        m0_rvalid_d = m0_gnt_s & ~bus.m0_we;
        m1_rvalid_d = m1_gnt_s & ~bus.m1_we;
        m0_rdata_d  = m0_rvalid_d ? bus.mem_data_out : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? bus.mem_data_out : m1_rdata_q;
    end

    // State and return-path registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
        end
    end

    assign bus.m0_gnt      = m0_gnt_s;
    assign bus.m1_gnt      = m1_gnt_s;
    assign bus.m0_rdata    = m0_rdata_q;
    assign bus.m1_rdata    = m1_rdata_q;
    assign bus.m0_rvalid   = m0_rvalid_q;
    assign bus.m1_rvalid   = m1_rvalid_q;
    assign bus.mem_wr_en   = mem_wr_en_s;
    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_data_in = mem_data_in_s;
    assign bus.arb_owner   = arb_owner_s;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_gnt0_q, stat_gnt0_d;
    logic [31:0] stat_gnt1_q, stat_gnt1_d;
    logic [31:0] stat_conflict_q, stat_conflict_d;
    logic        conflict_s;

    // Counter updates; a conflict is a waiting requester while the other master holds the grant.
    always_comb begin
        conflict_s      = (m0_gnt_s & bus.m1_req) | (m1_gnt_s & bus.m0_req);
        stat_gnt0_d     = stat_gnt0_q + {31'd0, m0_gnt_s};
        stat_gnt1_d     = stat_gnt1_q + {31'd0, m1_gnt_s};
        stat_conflict_d = stat_conflict_q + {31'd0, conflict_s};
    end

    // Statistics registers, wrapping naturally at 2^32.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stat_gnt0_q     <= 32'd0;
            stat_gnt1_q     <= 32'd0;
            stat_conflict_q <= 32'd0;
        end else begin
            stat_gnt0_q     <= stat_gnt0_d;
            stat_gnt1_q     <= stat_gnt1_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_gnt0     = stat_gnt0_q;
    assign stat_gnt1     = stat_gnt1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule
